fire8_squeeze_ofm_writer: RTL



---
 rtl/fire8_squeeze_ofm_writer_if.sv | 60 ++++++
 rtl/fire8_squeeze_ofm_writer.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/fire8_squeeze_ofm_writer_if.sv
// ---------------------------------------------------------------------------
// fire8_squeeze_ofm_writer_if
// Bundle between the fire8 squeeze layer (master) and its ofm RAM writer
// (slave).
//   fire8_squeeze_sample : one-cycle pulse, ofm valid in the same cycle
//   ofm[0:DSP_NO-1]      : parallel ofm words, WIDTH bits each
//   ram_we/addr/data     : RAM write port driven by the writer
//   ram_feedback         : one-cycle pulse, whole layer written
//   busy                 : writer is serialising a sample
//   overrun              : sticky, a sample was dropped
//   checksum             : (FIRE8_OFM_WRITER_CHECKSUM_EN only) sum of writes
// ---------------------------------------------------------------------------
interface fire8_squeeze_ofm_writer_if #(
    parameter int DSP_NO = 112,
    parameter int WIDTH  = 16,
    parameter int WOUT   = 8,
    parameter int ADDR_W = $clog2(DSP_NO * WOUT * WOUT)
);
    logic                    fire8_squeeze_sample;
    logic [WIDTH-1:0]        ofm [0:DSP_NO-1];
    logic                    ram_we;
    logic [ADDR_W-1:0]       ram_addr;
    logic [WIDTH-1:0]        ram_data;
    logic                    ram_feedback;
    logic                    busy;
    logic                    overrun;
`ifdef FIRE8_OFM_WRITER_CHECKSUM_EN
    logic [31:0]             checksum;
`endif

    // Squeeze-layer side.
    modport master (
        output fire8_squeeze_sample,
        output ofm,
        input  ram_we,
        input  ram_addr,
        input  ram_data,
        input  ram_feedback,
        input  busy,
        input  overrun
`ifdef FIRE8_OFM_WRITER_CHECKSUM_EN
        , input checksum
`endif
    );

    // Writer side.
    modport slave (
        input  fire8_squeeze_sample,
        input  ofm,
        output ram_we,
        output ram_addr,
        output ram_data,
        output ram_feedback,
        output busy,
        output overrun
`ifdef FIRE8_OFM_WRITER_CHECKSUM_EN
        , output checksum
`endif
    );
endinterface

// File: rtl/fire8_squeeze_ofm_writer.sv
// ---------------------------------------------------------------------------
// fire8_squeeze_ofm_writer
// Captures DSP_NO parallel ofm words per squeeze sample and writes them to
// the ofm RAM one word per cycle, channel-major (addr = ch*WOUT^2 + pix).
// After the last word of pixel WOUT^2-1 it pulses ram_feedback once and
// parks in DONE until reset.
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous reset, active-high
//   bus  : fire8_squeeze_ofm_writer_if.slave (sample/ofm in, RAM port,
//          ram_feedback, busy, overrun out)
// Optional: define FIRE8_OFM_WRITER_CHECKSUM_EN to add bus.checksum, the
// modulo-2^32 sum of every word written.
// ---------------------------------------------------------------------------
module fire8_squeeze_ofm_writer #(
    parameter int DSP_NO = 112,
    parameter int WIDTH  = 16,
    parameter int WOUT   = 8,
    parameter int ADDR_W = $clog2(DSP_NO * WOUT * WOUT)
) (
    input  logic                             clk,
    input  logic                             rst,
    fire8_squeeze_ofm_writer_if.slave        bus
);
    localparam int NPIX  = WOUT * WOUT;
    localparam int CH_W  = $clog2(DSP_NO);
    localparam int PIX_W = $clog2(NPIX);

    localparam logic [CH_W-1:0]   CH_LAST   = CH_W'(DSP_NO - 1);
    localparam logic [PIX_W-1:0]  PIX_LAST  = PIX_W'(NPIX - 1);
    localparam logic [ADDR_W-1:0] BASE_STEP = ADDR_W'(NPIX);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [CH_W-1:0]     ch_q, ch_d;
    logic [PIX_W-1:0]    pix_q, pix_d;
    logic [ADDR_W-1:0]   base_q, base_d;     // running ch*WOUT^2
    logic                overrun_q, overrun_d;
    logic                capture_s;
    logic [WIDTH-1:0]    shadow_q [0:DSP_NO-1];

    logic                ram_we_q, ram_we_d;
    logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
    logic [WIDTH-1:0]    ram_data_q, ram_data_d;
    logic                feedback_q, feedback_d;
    logic                busy_q, busy_d;

    // Next-state, counter and output-lookahead logic.
    always_comb begin
        state_d    = state_q;
        ch_d       = ch_q;
        pix_d      = pix_q;
        base_d     = base_q;
        overrun_d  = overrun_q;
        capture_s  = 1'b0;
        feedback_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.fire8_squeeze_sample) begin
                    capture_s = 1'b1;
                    ch_d      = {CH_W{1'b0}};
                    base_d    = {ADDR_W{1'b0}};
                    state_d   = S_WRITE;
                end else begin
                    state_d   = S_IDLE;
                end
            end
            S_WRITE: begin
                if (ch_q == CH_LAST) begin
                    // Final channel of this pixel: advance the pixel.
                    pix_d  = pix_q + PIX_W'(1);
                    ch_d   = {CH_W{1'b0}};
                    base_d = {ADDR_W{1'b0}};
                    if (pix_q == PIX_LAST) begin
                        state_d    = S_DONE;
                        feedback_d = 1'b1;
                        if (bus.fire8_squeeze_sample) begin
                            overrun_d = 1'b1;
                        end else begin
                            overrun_d = overrun_q;
                        end
                    end else if (bus.fire8_squeeze_sample) begin
                        // Back-to-back capture, no gap cycle.
                        capture_s = 1'b1;
                        state_d   = S_WRITE;
                    end else begin
                        state_d   = S_IDLE;
                    end
                end else begin
                    ch_d   = ch_q + CH_W'(1);
                    base_d = base_q + BASE_STEP;
                    if (bus.fire8_squeeze_sample) begin
                        overrun_d = 1'b1;
                    end else begin
                        overrun_d = overrun_q;
                    end
                end
            end
            S_DONE: begin
                state_d = S_DONE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // RAM port is registered: compute the write for the coming cycle.
        busy_d   = (state_d == S_WRITE);
        ram_we_d = (state_d == S_WRITE);
        if (ram_we_d) begin
            ram_addr_d = base_d + ADDR_W'(pix_d);
            if (capture_s) begin
                ram_data_d = bus.ofm[0];
            end else begin
                ram_data_d = shadow_q[ch_d];
            end
        end else begin
            ram_addr_d = ram_addr_q;
            ram_data_d = ram_data_q;
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            ch_q       <= {CH_W{1'b0}};
            pix_q      <= {PIX_W{1'b0}};
            base_q     <= {ADDR_W{1'b0}};
            overrun_q  <= 1'b0;
            ram_we_q   <= 1'b0;
            ram_addr_q <= {ADDR_W{1'b0}};
            ram_data_q <= {WIDTH{1'b0}};
            feedback_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            ch_q       <= ch_d;
            pix_q      <= pix_d;
            base_q     <= base_d;
            overrun_q  <= overrun_d;
            ram_we_q   <= ram_we_d;
            ram_addr_q <= ram_addr_d;
            ram_data_q <= ram_data_d;
            feedback_q <= feedback_d;
            busy_q     <= busy_d;
        end
    end

    // Shadow buffer: holds the captured sample while it is serialised.
    always_ff @(posedge clk) begin
        if (!rst && capture_s) begin
            shadow_q <= bus.ofm;
        end
    end

    assign bus.ram_we       = ram_we_q;
    assign bus.ram_addr     = ram_addr_q;
    assign bus.ram_data     = ram_data_q;
    assign bus.ram_feedback = feedback_q;
    assign bus.busy         = busy_q;
    assign bus.overrun      = overrun_q;

`ifdef FIRE8_OFM_WRITER_CHECKSUM_EN
    logic [31:0] checksum_q;

    // Running sum of written words, one cycle behind the write.
    always_ff @(posedge clk) begin
        if (rst) begin
            checksum_q <= 32'd0;
        end else if (ram_we_q) begin
            checksum_q <= checksum_q + 32'(ram_data_q);
        end
    end

    assign bus.checksum = checksum_q;
`endif
endmodule
